// File: rtl/temporizador_pkg.sv
// Shared types and defaults for the multi-channel sequenced timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package temporizador_pkg;

  // Sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_N_CH    = 3;
  localparam int DEF_CNT_W   = 5;
  localparam int DEF_PRESC_W = 8;

  // Width of a channel index; never below one bit so N_CH=1 still has a port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..presc and flags the last cycle of each unit.
// Latency: tick is combinational from the count register (same cycle).
// Backpressure: none; clr forces the count back to 0 at the next edge.
module divisor_tick
  import temporizador_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_tick;

  // A unit ends in the cycle where the count has reached the setting.
  assign w_tick = (r_cnt == presc);
  assign tick   = w_tick;

  // Count up, wrapping to zero after the tick cycle or on an explicit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/temporizador_multicanal.sv
// Sequences N_CH channels one after another, each held for dur*(presc+1) cycles.
// Latency: enter at edge k -> active[0]/busy from cycle k+1; all outputs registered.
// Backpressure: none; enter ignored while busy, abort wins over everything.
module temporizador_multicanal
  import temporizador_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enter,
  input  logic                        abort,
  input  logic                        repeat_en,
  input  logic [PRESC_W-1:0]          presc,
  input  logic [N_CH*CNT_W-1:0]       dur,
  output logic [N_CH-1:0]             active,
  output logic [N_CH-1:0]             flags,
  output logic                        done,
  output logic                        busy,
  output logic [ch_width(N_CH)-1:0]   ch_idx
);

  localparam int CH_W = ch_width(N_CH);

  // The internal counters run one cycle ahead of the registered outputs:
  // r_ch / r_unit / prescaler count describe the cycle the outputs will show
  // after the next edge, so flags can be registered yet land in the last
  // active cycle of a channel.
  state_t                  r_state;
  logic [CH_W-1:0]         r_ch;
  logic [CNT_W-1:0]        r_unit;
  logic                    r_wrap;
  logic [N_CH*CNT_W-1:0]   r_dur;
  logic [PRESC_W-1:0]      r_presc;

  logic [N_CH-1:0]         r_active;
  logic [N_CH-1:0]         r_flags;
  logic                    r_done;
  logic                    r_busy;
  logic [CH_W-1:0]         r_ch_idx;

  logic                    w_start;
  logic                    w_stop;
  logic                    w_go;
  logic [N_CH*CNT_W-1:0]   w_dur_sel;
  logic [PRESC_W-1:0]      w_presc_sel;
  logic [CH_W-1:0]         w_vch;
  logic [CNT_W-1:0]        w_vunit;
  logic [CNT_W-1:0]        w_cur_dur;
  logic [CNT_W-1:0]        w_dur_m1;
  logic                    w_zero;
  logic                    w_tick;
  logic                    w_last;
  logic                    w_last_ch;
  logic [N_CH-1:0]         w_onehot;
  logic                    w_clr;

  state_t                  w_nxt_state;
  logic [CH_W-1:0]         w_nxt_ch;
  logic [CNT_W-1:0]        w_nxt_unit;
  logic                    w_nxt_wrap;
  logic [N_CH-1:0]         w_nxt_active;
  logic [N_CH-1:0]         w_nxt_flags;
  logic                    w_nxt_done;
  logic                    w_nxt_busy;
  logic [CH_W-1:0]         w_nxt_ch_idx;

  // While idle the live inputs are looked at so the very first output cycle
  // already uses the values being snapshotted; afterwards only the snapshot.
  assign w_dur_sel   = (r_state == IDLE) ? dur   : r_dur;
  assign w_presc_sel = (r_state == IDLE) ? presc : r_presc;
  assign w_vch       = (r_state == IDLE) ? '0    : r_ch;
  assign w_vunit     = (r_state == IDLE) ? '0    : r_unit;

  assign w_cur_dur = w_dur_sel[int'(w_vch)*CNT_W +: CNT_W];
  assign w_dur_m1  = w_cur_dur - CNT_W'(1);
  assign w_zero    = (w_cur_dur == '0);
  assign w_last    = w_zero || (w_tick && (w_vunit == w_dur_m1));
  assign w_last_ch = (w_vch == CH_W'(N_CH - 1));
  assign w_onehot  = N_CH'(1) << w_vch;

  // r_wrap marks the cycle showing the final completion; repeat_en is judged there.
  assign w_start = (r_state == IDLE) && enter;
  assign w_stop  = abort || ((r_state == RUN) && r_wrap && !repeat_en);
  assign w_go    = !w_stop && (w_start || (r_state == RUN));

  divisor_tick #(
    .PRESC_W (PRESC_W)
  ) u_divisor_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .presc (w_presc_sel),
    .tick  (w_tick)
  );

  // Next-state and next-output decode; abort/stop first, then normal sequencing.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_ch     = r_ch;
    w_nxt_unit   = r_unit;
    w_nxt_wrap   = 1'b0;
    w_clr        = 1'b1;
    w_nxt_active = '0;
    w_nxt_flags  = '0;
    w_nxt_done   = 1'b0;
    w_nxt_busy   = 1'b0;
    w_nxt_ch_idx = '0;
    if (w_stop) begin
      w_nxt_state = IDLE;
      w_nxt_ch    = '0;
      w_nxt_unit  = '0;
    end else if (w_go) begin
      w_nxt_state  = RUN;
      w_nxt_busy   = 1'b1;
      w_nxt_ch_idx = w_vch;
      w_nxt_active = w_zero ? '0 : w_onehot;
      if (w_last) begin
        w_nxt_flags = w_onehot;
        w_nxt_unit  = '0;
        if (w_last_ch) begin
          w_nxt_done = 1'b1;
          w_nxt_ch   = '0;
          w_nxt_wrap = 1'b1;
        end else begin
          w_nxt_ch = w_vch + CH_W'(1);
        end
      end else begin
        w_clr      = 1'b0;
        w_nxt_ch   = w_vch;
        w_nxt_unit = w_tick ? (w_vunit + CNT_W'(1)) : w_vunit;
      end
    end else begin
      w_nxt_state = IDLE;
      w_nxt_ch    = '0;
      w_nxt_unit  = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Channel/unit position and the repeat-decision marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_unit <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_ch   <= w_nxt_ch;
      r_unit <= w_nxt_unit;
      r_wrap <= w_nxt_wrap;
    end
  end

  // Capture durations and prescaler when a sequence is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dur   <= '0;
      r_presc <= '0;
    end else if (w_start && !abort) begin
      r_dur   <= dur;
      r_presc <= presc;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ch_idx <= '0;
    end else begin
      r_active <= w_nxt_active;
      r_flags  <= w_nxt_flags;
      r_done   <= w_nxt_done;
      r_busy   <= w_nxt_busy;
      r_ch_idx <= w_nxt_ch_idx;
    end
  end

  assign active = r_active;
  assign flags  = r_flags;
  assign done   = r_done;
  assign busy   = r_busy;
  assign ch_idx = r_ch_idx;

endmodule
